// File: rtl/ask_tx_scheduler.sv
// ask_tx_scheduler
//   Frame scheduler for the ASK transmit path. It accepts one byte per
//   valid/ready handshake and plays it out as a framed symbol stream:
//   an alternating preamble (1,0,1,...), a start symbol (1), eight data
//   symbols MSB-first, and a stop symbol (0). Every symbol lasts
//   SYM_CYCLES clocks. All outputs are registered.
//
// Parameters
//   SYM_CYCLES     sys_clk cycles per symbol (2..256)
//   PREAMBLE_BITS  preamble length in symbols (1..15)
//
// Ports
//   sys_clk      system clock, rising edge
//   reset        synchronous active-high reset
//   tx_data      byte to send, sampled only on handshake
//   tx_valid     requester has a byte
//   tx_ready     scheduler can accept a byte (IDLE only)
//   sym_bit      current symbol value to the modulator
//   carrier_en   modulator enable, high for the whole frame
//   sym_strobe   one-cycle pulse on the first cycle of every symbol
//   busy         frame in progress
//   frame_done   one-cycle pulse on the cycle IDLE is re-entered
//   frame_count  completed frames, wraps 255 -> 0
module ask_tx_scheduler #(
  parameter int SYM_CYCLES    = 16,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sym_bit,
  output logic       carrier_en,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  // The symbol timer spans 0..SYM_CYCLES-1; the bit counter must hold the
  // longer of the preamble and the 8-bit data phase.
  localparam int CNT_W   = $clog2(SYM_CYCLES);
  localparam int BIT_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int BIT_W   = $clog2(BIT_MAX);

  localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYM_CYCLES - 1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sym_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;

  wire sym_end = (sym_cnt == SYM_LAST);

  // Outputs are computed for the state being entered, so each one is a
  // flop and the first cycle of a new symbol already shows its value.
  // NOTE: every assignment in this sequential block is non-blocking so all
  // flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      bit_cnt     <= '0;
      tx_ready    <= 1'b0;
      sym_bit     <= 1'b0;
      carrier_en  <= 1'b0;
      sym_strobe  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      // NOTE: shift_reg is deliberately left out of reset; it is always
      // loaded on the handshake before any of its bits reach sym_bit.
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            state      <= PREAMBLE;
            sym_cnt    <= '0;
            bit_cnt    <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            carrier_en <= 1'b1;
            sym_bit    <= 1'b1;
            sym_strobe <= 1'b1;
          end else begin
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            carrier_en <= 1'b0;
            sym_bit    <= 1'b0;
            sym_strobe <= 1'b0;
          end
        end

        default: begin
          if (!sym_end) begin
            sym_cnt    <= sym_cnt + CNT_W'(1);
            sym_strobe <= 1'b0;
          end else begin
            sym_cnt    <= '0;
            sym_strobe <= 1'b1;
            case (state)
              PREAMBLE: begin
                if (bit_cnt == PRE_LAST) begin
                  state   <= START;
                  bit_cnt <= '0;
                  sym_bit <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  sym_bit <= ~sym_bit;  // preamble alternates
                end
              end

              START: begin
                state   <= DATA;
                bit_cnt <= '0;
                sym_bit <= shift_reg[7];
              end

              DATA: begin
                // The next data symbol is the bit that moves into [7].
                shift_reg <= {shift_reg[6:0], 1'b0};
                if (bit_cnt == DATA_LAST) begin
                  state   <= STOP;
                  bit_cnt <= '0;
                  sym_bit <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  sym_bit <= shift_reg[6];
                end
              end

              default: begin  // STOP: close the frame
                state       <= IDLE;
                tx_ready    <= 1'b1;
                busy        <= 1'b0;
                carrier_en  <= 1'b0;
                sym_bit     <= 1'b0;
                sym_strobe  <= 1'b0;
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ask_tx_scheduler.sv
// tb_ask_tx_scheduler
//   Directed bench for ask_tx_scheduler. Instance dut uses SYM_CYCLES=4,
//   PREAMBLE_BITS=4 (56-cycle frames); instance dut_wrap uses SYM_CYCLES=2,
//   PREAMBLE_BITS=1 for the frame counter wrap. Inputs are driven and
//   outputs sampled on the falling edge.
module tb_ask_tx_scheduler;

  localparam int S     = 4;
  localparam int P     = 4;
  localparam int FRAME = (P + 10) * S;

  logic       sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       reset, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, sym_bit, carrier_en, sym_strobe, busy, frame_done;
  logic [7:0] frame_count;

  logic       reset_b, tx_valid_b;
  logic [7:0] tx_data_b;
  logic       tx_ready_b, sym_bit_b, carrier_en_b, sym_strobe_b, busy_b, frame_done_b;
  logic [7:0] frame_count_b;

  ask_tx_scheduler #(.SYM_CYCLES(S), .PREAMBLE_BITS(P)) dut (
    .sys_clk(sys_clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sym_bit(sym_bit), .carrier_en(carrier_en),
    .sym_strobe(sym_strobe), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  ask_tx_scheduler #(.SYM_CYCLES(2), .PREAMBLE_BITS(1)) dut_wrap (
    .sys_clk(sys_clk), .reset(reset_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .sym_bit(sym_bit_b), .carrier_en(carrier_en_b),
    .sym_strobe(sym_strobe_b), .busy(busy_b), .frame_done(frame_done_b),
    .frame_count(frame_count_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected symbol value for symbol index sym of a frame carrying data.
  function automatic logic exp_bit(input logic [7:0] data, input int sym);
    if (sym < P)      return (sym % 2) == 0;
    if (sym == P)     return 1'b1;
    if (sym <= P + 8) return data[P + 8 - sym];
    return 1'b0;
  endfunction

  // Entered at the falling edge of the first frame cycle; returns at the
  // falling edge of the frame_done cycle. tx_data is changed mid-frame to
  // next_data to show it has no effect on the frame in flight.
  task automatic check_frame(input logic [7:0] data, input logic [7:0] exp_count,
                             input logic [7:0] next_data);
    int framed = 0;
    int strobes = 0;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("sym_bit[%0d] data=%h", i, data), sym_bit, exp_bit(data, i / S));
      check($sformatf("strobe[%0d] data=%h", i, data), sym_strobe, (i % S) == 0);
      if (busy && carrier_en && !tx_ready && !frame_done) framed++;
      if (sym_strobe) strobes++;
      if (i == 5) tx_data = next_data;
      @(negedge sys_clk);
    end
    check("framed_cycles", framed, FRAME);
    check("strobe_count", strobes, P + 10);
    check("done_pulse", frame_done, 1);
    check("done_ready", tx_ready, 1);
    check("done_busy", busy, 0);
    check("done_carrier", carrier_en, 0);
    check("done_count", frame_count, exp_count);
  endtask

  initial begin
    int quiet;
    int dones;
    logic [7:0] fc1, fc255, fc256, fc257;

    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
    reset_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = 8'h00;

    // Reset held 3 cycles with tx_valid high: reset wins, outputs all zero.
    repeat (3) begin
      @(negedge sys_clk);
      check("reset_outputs",
            {tx_ready, sym_bit, carrier_en, sym_strobe, busy, frame_done, frame_count}, 0);
    end
    reset = 1'b0; tx_valid = 1'b0;
    @(negedge sys_clk);
    check("post_reset_ready", tx_ready, 1);
    check("post_reset_busy", busy, 0);
    check("post_reset_count", frame_count, 0);

    // Single frame 0x60.
    tx_data = 8'h60; tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    check("hs_ready_low", tx_ready, 0);
    check_frame(8'h60, 8'd1, 8'h60);
    @(negedge sys_clk);
    check("done_drops", frame_done, 0);
    check("idle_after_60", busy, 0);

    // Held tx_valid: 0xA5 then 0x3C back to back, one IDLE gap.
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge sys_clk);
    check_frame(8'hA5, 8'd2, 8'h3C);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    check_frame(8'h3C, 8'd3, 8'h11);
    @(negedge sys_clk);
    check("b2b_idle_after", busy, 0);
    check("b2b_done_drops", frame_done, 0);

    // Reset at cycle 20 of a frame.
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    repeat (19) @(negedge sys_clk);
    check("mid_frame_busy", busy, 1);
    reset = 1'b1;
    @(negedge sys_clk);
    check("mid_reset_outputs",
          {tx_ready, sym_bit, carrier_en, sym_strobe, busy, frame_done, frame_count}, 0);
    check("mid_reset_no_done", frame_done, 0);
    reset = 1'b0;
    @(negedge sys_clk);
    check("mid_reset_ready", tx_ready, 1);
    check("mid_reset_count", frame_count, 0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    check_frame(8'hFF, 8'd1, 8'hFF);

    // Idle with tx_valid low for 1000 cycles.
    quiet = 0;
    repeat (1000) begin
      @(negedge sys_clk);
      if (busy || carrier_en || sym_strobe) quiet++;
    end
    check("idle_quiet_cycles", quiet, 0);
    check("idle_ready", tx_ready, 1);

    // Frame counter wrap on the small instance, tx_valid held high.
    reset_b = 1'b0; tx_data_b = 8'h55; tx_valid_b = 1'b1;
    dones = 0; fc1 = '0; fc255 = '0; fc256 = 8'hEE; fc257 = '0;
    for (int c = 0; c < 257 * 23 + 100 && dones < 257; c++) begin
      @(negedge sys_clk);
      if (frame_done_b) begin
        dones++;
        if (dones == 1)   fc1   = frame_count_b;
        if (dones == 255) fc255 = frame_count_b;
        if (dones == 256) fc256 = frame_count_b;
        if (dones == 257) begin
          fc257 = frame_count_b;
          tx_valid_b = 1'b0;
        end
      end
    end
    check("wrap_done_pulses", dones, 257);
    check("wrap_count_1", fc1, 1);
    check("wrap_count_255", fc255, 255);
    check("wrap_count_256", fc256, 0);
    check("wrap_count_257", fc257, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ask_tx_scheduler.md
# ask_tx_scheduler

Frame scheduler for the ASK transmit path of the modem. It accepts bytes over a valid/ready handshake and sequences each byte into a framed symbol stream: preamble, start bit, 8 data bits MSB-first, then stop. It drives the ASK modulator with one bit per symbol period, a carrier enable and a symbol strobe. A frame counter is exported for the LED display.

## Interface
- SYM_CYCLES, 16, sys_clk cycles per symbol; legal range 2..256
- PREAMBLE_BITS, 8, preamble length in symbols; legal range 1..15
- sys_clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- tx_data  input  8  byte to transmit; sampled only on handshake
- tx_valid  input  1  requester has a byte
- tx_ready  output  1  scheduler can accept a byte (high only in IDLE)
- sym_bit  output  1  current symbol value to modulator (1 = carrier on)
- carrier_en  output  1  modulator enable; high for the whole frame
- sym_strobe  output  1  one-cycle pulse on the first cycle of every symbol
- busy  output  1  frame in progress (state != IDLE)
- frame_done  output  1  one-cycle pulse after the last stop cycle
- frame_count  output  8  completed frames, wraps 255 -> 0

## Operation
- States: IDLE, PREAMBLE, START, DATA, STOP. All outputs are registered.
- IDLE: tx_ready=1, busy=0, carrier_en=0, sym_bit=0.
  - A handshake (tx_valid & tx_ready) latches tx_data into a shift register.
  - The block then goes to PREAMBLE with sym_cnt=0 and bit_cnt=0.
- PREAMBLE: PREAMBLE_BITS symbols, alternating 1,0,1,... starting with 1.
- START: one symbol, sym_bit=1.
- DATA: 8 symbols, sym_bit = shift_reg[7], shift left by one at each symbol end.
- STOP: one symbol with sym_bit=0 and carrier_en=1. Then the block returns to IDLE.
- carrier_en=1 and busy=1 in PREAMBLE, START, DATA and STOP.
- Symbol timer:
  - sym_cnt counts 0..SYM_CYCLES-1.
  - sym_strobe=1 exactly when sym_cnt==0 in a non-IDLE state.
  - bit_cnt advances on sym_cnt==SYM_CYCLES-1.
- Counter widths are sized by $clog2 of their ranges. No other arithmetic.
- Frame length is (PREAMBLE_BITS+10)*SYM_CYCLES cycles.
- frame_done pulses on the cycle IDLE is re-entered after STOP. frame_count increments on the same edge.
- tx_valid or tx_data changes while busy are ignored. A held tx_valid is accepted on the first IDLE cycle.
- Back-to-back frames: the minimum gap is exactly one IDLE cycle, which is the handshake cycle. Every frame carries a full preamble.
- Reset (any state, including mid-frame):
  - The next edge forces IDLE and drops the frame.
  - Resets frame_count to 0.
  - No frame_done pulse is produced.
- Reset values (held while reset=1): tx_ready=0, sym_bit=0, carrier_en=0, sym_strobe=0, busy=0, frame_done=0, frame_count=0.
- tx_ready rises on the first edge with reset=0.

## Timing
- Handshake at edge k. Cycle k+1 has busy=1, carrier_en=1, sym_bit=1, sym_strobe=1 and tx_ready=0.
- Each sym_bit value is held for exactly SYM_CYCLES cycles. Transitions occur only at symbol boundaries, coincident with sym_strobe.
- The last STOP cycle is k+(PREAMBLE_BITS+10)*SYM_CYCLES. The next cycle has IDLE, tx_ready=1 and frame_done=1.
- If tx_valid=1 in that cycle, the next frame starts one cycle later.
- frame_count is valid in the same cycle as frame_done.
- Simultaneous reset and tx_valid: reset wins and no byte is accepted.

## Test plan
- Reset held for 3 cycles, then released: all outputs stay at reset values during reset. tx_ready=1 from the first post-reset cycle. frame_count=0.
- SYM_CYCLES=4, PREAMBLE_BITS=4, send 8'h60:
  - Per-symbol sym_bit is 1,0,1,0,1,0,1,1,0,0,0,0,0,0.
  - Each value is held 4 cycles, with 14 sym_strobe pulses.
  - carrier_en is high for 56 cycles; frame_done fires 57 cycles after the handshake.
  - frame_count=1.
- tx_valid held high with two bytes 8'hA5 then 8'h3C: each accepted once, one-cycle IDLE gap between frames. tx_data changes during the first frame have no effect on it. frame_count=2.
- Assert reset at cycle 20 of a frame: the next cycle shows all reset values and no frame_done. After release, a new 8'hFF frame transmits a complete preamble.
- Send 256 frames (SYM_CYCLES=2, PREAMBLE_BITS=1): frame_count wraps to 0 on the 256th frame_done and reads 1 after the 257th.
- tx_valid=0 indefinitely after reset: busy=0, carrier_en=0 and sym_strobe=0 throughout 1000 cycles.
